// File: rtl/execute_cycle_if.sv
// Bundles the ID/EX inputs and the EX/MEM outputs of the execute stage.
// The slave modport is the execute stage. The master modport is whoever
// drives the ID/EX side and observes the results.
interface execute_cycle_if;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        ALUSrcE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [1:0]  ForwardA_E;
    logic [1:0]  ForwardB_E;
    logic [31:0] ResultW;

    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage of the five-stage RISC-V pipeline: operand forwarding, ALU,
// beq resolution and branch target, followed by the EX/MEM register.
// The branch decision and target are combinational so fetch can redirect
// in the same cycle.
module execute_cycle (
    input  logic           clk,
    input  logic           rst,
    execute_cycle_if.slave bus
);
    logic [31:0] src_a;
    logic [31:0] src_b_interim;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero;

    logic        reg_write_d,   reg_write_q;
    logic        mem_write_d,   mem_write_q;
    logic        result_src_d,  result_src_q;
    logic [4:0]  rd_d,          rd_q;
    logic [31:0] pc_plus4_d,    pc_plus4_q;
    logic [31:0] write_data_d,  write_data_q;
    logic [31:0] alu_result_d,  alu_result_q;

    // Forwarding muxes, ALU and branch resolution; the EX/MEM result register feeds back as forward source 10
    always_comb begin
        src_a         = bus.RD1_E;
        src_b_interim = bus.RD2_E;
        alu_result    = 32'h0;

        case (bus.ForwardA_E)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = bus.RD1_E;
        endcase

        case (bus.ForwardB_E)
            2'b01:   src_b_interim = bus.ResultW;
            2'b10:   src_b_interim = alu_result_q;
            default: src_b_interim = bus.RD2_E;
        endcase

        src_b = bus.ALUSrcE ? bus.Imm_Ext_E : src_b_interim;

        case (bus.ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {31'b0, ($signed(src_a) < $signed(src_b))};
            default: alu_result = 32'h0;
        endcase

        zero = (alu_result == 32'h0);
    end

    // Next-state values for the EX/MEM register; store data is taken before the immediate mux
    always_comb begin
        reg_write_d  = bus.RegWriteE;
        mem_write_d  = bus.MemWriteE;
        result_src_d = bus.ResultSrcE;
        rd_d         = bus.RD_E;
        pc_plus4_d   = bus.PCPlus4E;
        write_data_d = src_b_interim;
        alu_result_d = alu_result;
    end

    // EX/MEM register, captured every cycle and cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= 5'd0;
            pc_plus4_q   <= 32'h0;
            write_data_q <= 32'h0;
            alu_result_q <= 32'h0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            write_data_q <= write_data_d;
            alu_result_q <= alu_result_d;
        end
    end

    assign bus.PCSrcE      = zero & bus.BranchE;
    assign bus.PCTargetE   = bus.PCE + bus.Imm_Ext_E;
    assign bus.RegWriteM   = reg_write_q;
    assign bus.MemWriteM   = mem_write_q;
    assign bus.ResultSrcM  = result_src_q;
    assign bus.RD_M        = rd_q;
    assign bus.PCPlus4M    = pc_plus4_q;
    assign bus.WriteDataM  = write_data_q;
    assign bus.ALU_ResultM = alu_result_q;
endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RISC-V pipeline, between the decode stage (ID/EX register) and the memory stage. It selects forwarded operands, runs the ALU, resolves branches, and produces the branch target. Results are captured into the EX/MEM pipeline register. The branch decision and target leave combinationally, the same cycle, so fetch can redirect and the hazard unit can flush decode and execute.

## Interface
Parameters: none (fixed 32-bit datapath, 5-bit register indices).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RegWriteE  in  1  register-write enable from ID/EX
- MemWriteE  in  1  store enable from ID/EX
- ResultSrcE  in  1  writeback select (0 ALU, 1 memory) from ID/EX
- ALUSrcE  in  1  operand B select (0 register, 1 immediate)
- BranchE  in  1  instruction is beq
- ALUControlE  in  3  ALU operation
- RD1_E, RD2_E  in  32 each  register-file read data
- Imm_Ext_E  in  32  sign-extended immediate
- RD_E  in  5  destination register
- PCE, PCPlus4E  in  32 each  instruction PC and PC+4
- ForwardA_E, ForwardB_E  in  2 each  forwarding selects from hazard unit
- ResultW  in  32  writeback-stage result (forward source)
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  32  branch target (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls
- RD_M  out  5  registered destination
- PCPlus4M  out  32  registered PC+4
- WriteDataM  out  32  registered store data (forwarded operand B before immediate mux)
- ALU_ResultM  out  32  registered ALU result; also the EX/MEM forward source

## Operation
- Forward mux A (SrcA) on ForwardA_E: 00 RD1_E, 01 ResultW, 10 ALU_ResultM, 11 RD1_E.
- Forward mux B (Src_B_interim) on ForwardB_E: same encoding using RD2_E.
- SrcB = ALUSrcE ? Imm_Ext_E : Src_B_interim.
- ALU operations on ALUControlE:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt (signed compare, result 1 or 0)
  - any other code gives result 32'h0
- Add and sub are modulo 2^32. No overflow trap.
- ZeroE = (ALU result == 0). PCSrcE = ZeroE & BranchE.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^32, computed regardless of BranchE.
- EX/MEM register captures on every rising clk:
  - RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E
  - Src_B_interim into WriteDataM
  - ALU result into ALU_ResultM
- No stall or flush input. Execute-stage bubbles arrive as zeroed controls from the ID/EX flush.
- Reset (rst low): all registered outputs go to 0 immediately and asynchronously, and stay 0 while rst is low. PCSrcE and PCTargetE stay combinational functions of their inputs.

## Timing
- PCSrcE and PCTargetE are valid in the same cycle the instruction occupies EX, with zero latency.
- Registered outputs have 1-cycle latency: an instruction in EX during cycle n appears on the *M outputs after edge n+1.
- ALU_ResultM forwarding is back-to-back. An instruction in EX during cycle n+1 can select ForwardA_E=10 and receive the previous instruction's result with no bubble.
- Reset deasserted mid-stream: the first capture occurs on the first rising clk with rst high. Contents present before reset are lost.
- A branch taken with RegWriteE=0 still propagates its zero controls to M, so there is no side effect.

## Test plan
- Reset: drive RD1_E=5, RegWriteE=1, then assert rst low between edges. Required: all *M outputs read 0 before the next edge and hold 0 while rst is low.
- Add and forwarding:
  - RD1_E=7, RD2_E=3, ALUControlE=000, ForwardA/B=00. Required: ALU_ResultM=10 next cycle.
  - Next instruction uses ForwardA_E=10 with RD1_E=0, RD2_E=1. Required: ALU_ResultM=11.
- Forward from writeback: ForwardB_E=01, ResultW=32'h0000_0100, ALUSrcE=0, SrcA=1, sub. Required: ALU_ResultM=32'hFFFF_FF01 and WriteDataM=32'h100.
- Immediate path and store data: ALUSrcE=1, Imm_Ext_E=8, RD2_E=32'hDEAD_BEEF, add with RD1_E=32'h1000, MemWriteE=1. Required: ALU_ResultM=32'h1008, WriteDataM=32'hDEAD_BEEF, MemWriteM=1.
- Branch:
  - BranchE=1, ALUControlE=001, RD1_E=RD2_E=42, PCE=32'h40, Imm_Ext_E=32'hFFFF_FFF8. Required: same-cycle PCSrcE=1, PCTargetE=32'h38.
  - Same with RD2_E=41. Required: PCSrcE=0.
- slt signed and undefined op:
  - RD1_E=32'hFFFF_FFFF, RD2_E=1, ALUControlE=101. Required: ALU_ResultM=1.
  - ALUControlE=111. Required: ALU_ResultM=0, and PCSrcE=BranchE.
